// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: definitions shared by the CPU data-memory responder and its
// storage bank.
//   state_e      : responder FSM states (IDLE, RD_WAIT, RESP)
//   DATA_W_DEF   : default data word width
//   ADDR_W_DEF   : default byte address width
//   BE_ALL       : all byte enables set, for the default data width
//   align_mask() : byte-offset mask for a word of the given size in bytes
package cpu_mem_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 32;

   localparam logic [DATA_W_DEF/8-1:0] BE_ALL = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_e;

   // Address bits that must be zero for a word-aligned access.
   function automatic int unsigned align_mask(input int unsigned bytes_per_word);
      return bytes_per_word - 1;
   endfunction

endpackage

// File: rtl/mem_bank_be.sv
// mem_bank_be: synchronous RAM with one byte-masked write port and one
// registered read port. Contents are never reset.
//   clk_i   : clock
//   we_i    : write enable
//   be_i    : write byte enables (bit i covers bits 8i+7:8i)
//   waddr_i : write word index
//   wdata_i : write data
//   re_i    : read enable; rdata_o updates only on an enabled read
//   raddr_i : read word index
//   rdata_o : registered read data, held between reads
module mem_bank_be #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 256,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic [IDX_W-1:0]    waddr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic                re_i,
   input  logic [IDX_W-1:0]    raddr_i,
   output logic [DATA_W-1:0]   rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < DATA_W/8; i++) begin
            if (be_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the datapath load/store port.
// Accepts one request at a time, commits stores on the acceptance edge,
// returns load data RD_LAT cycles after acceptance and flags misaligned or
// out-of-range accesses.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid / req_ready : request handshake (req_ready registered)
//   req_write, req_addr, req_wdata, req_be : request payload
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata, rsp_err    : response payload
//   dbg_state_o           : current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge with req_valid && req_ready,
// a response on a rising edge with rsp_valid && rsp_ready. Response outputs
// hold steady until they transfer; request inputs matter only at acceptance.
module data_mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned RD_LAT      = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic [1:0]          dbg_state_o
);

   localparam int unsigned OFF_W = $clog2(DATA_W/8);
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = $clog2(RD_LAT+1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               err_q, err_d;
   logic               rd_ok_q, rd_ok_d;
   logic               ready_q, ready_d;

   logic               accept;
   logic               acc_err;
   logic [IDX_W-1:0]   word_idx;
   logic [DATA_W-1:0]  ram_rdata;

   assign accept   = req_valid && ready_q;
   assign word_idx = req_addr[IDX_W+OFF_W-1:OFF_W];
   // Upper address bits only feed the range check, never the index.
   assign acc_err  = ((req_addr & ADDR_W'(align_mask(DATA_W/8))) != '0) ||
                     ((req_addr >> OFF_W) >= ADDR_W'(DEPTH_WORDS));

   mem_bank_be #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH_WORDS)
   ) u_bank (
      .clk_i   (clk),
      .we_i    (accept && req_write && !acc_err),
      .be_i    (req_be),
      .waddr_i (word_idx),
      .wdata_i (req_wdata),
      .re_i    (accept && !req_write && !acc_err),
      .raddr_i (word_idx),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rd_ok_q <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rd_ok_q <= rd_ok_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rd_ok_d = rd_ok_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               err_d   = acc_err;
               rd_ok_d = !req_write && !acc_err;
               // Counter holds cycles elapsed since acceptance.
               cnt_d   = CNT_W'(1);
               if (acc_err || req_write || RD_LAT == 1) state_d = RESP;
               else                                      state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (cnt_q == CNT_W'(RD_LAT-1)) state_d = RESP;
            else                           cnt_d   = cnt_q + CNT_W'(1);
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b0;
               rd_ok_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Registered ready: low during reset, high the edge after the
      // FSM settles in IDLE.
      ready_d = (state_d == IDLE);
   end

   assign req_ready   = ready_q;
   assign rsp_valid   = (state_q == RESP);
   assign rsp_err     = rsp_valid && err_q;
   // RAM read register is only loaded at acceptance, so it holds still
   // for the whole response.
   assign rsp_rdata   = (rsp_valid && rd_ok_q) ? ram_rdata : '0;
   assign dbg_state_o = state_q;

endmodule
